core_seq: RTL
=============

CORE_SEQ -- requirements
Module: core_seq

Interface
REQ-001 Parameter TIMEOUT_W, default 8: bit width of the bus response watchdog counter.
REQ-002 Parameter XLEN, default 32: width of the retired-instruction counter.
REQ-003 clk  input  1  single core clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ifu_req  output  1  fetch request to instruction memory; held high until accepted.
REQ-006 ifu_rsp_valid  input  1  instruction data valid this cycle.
REQ-007 inst_en  output  1  one-cycle load enable for the instruction register.
REQ-008 dec_mem_read  input  1  decoded load, from the decode unit.
REQ-009 dec_mem_write  input  1  decoded store, from the decode unit.
REQ-010 dec_rd_write  input  1  decoded destination-register write.
REQ-011 dec_ebreak  input  1  decoded ebreak.
REQ-012 lsu_req  output  1  data memory request; held high until accepted.
REQ-013 lsu_we  output  1  data request is a write; valid only while lsu_req=1.
REQ-014 lsu_rsp_valid  input  1  data memory response/ack this cycle.
REQ-015 rd_write_en  output  1  register file write strobe.
REQ-016 pc_update  output  1  PC register load strobe (next PC from execute path).
REQ-017 halted  output  1  core stopped (ebreak or bus error).
REQ-018 bus_error  output  1  watchdog expired on fetch or data access.
REQ-019 inst_retired  output  XLEN  count of retired instructions.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, DECODE, MEM, WB, HALT and ERROR; the state SHALL be encoded as a registered value.
REQ-021 From IDLE, the FSM SHALL move to FETCH unconditionally after 1 cycle.
REQ-022 In FETCH: ifu_req=1. On ifu_rsp_valid=1, inst_en=1 in that same cycle and the next state is DECODE.
REQ-023 DECODE SHALL last exactly 1 cycle, with priority ebreak > memory:
  - dec_ebreak=1 -> HALT;
  - else dec_mem_read|dec_mem_write -> MEM;
  - else -> WB.
REQ-024 In MEM: lsu_req=1 and lsu_we=dec_mem_write. On lsu_rsp_valid=1 the next state is WB.
REQ-025 WB SHALL last exactly 1 cycle: pc_update=1, rd_write_en=dec_rd_write, inst_retired increments by 1; next state is FETCH.
REQ-026 inst_retired SHALL wrap from all-ones to 0.
REQ-027 ebreak SHALL NOT pass through WB: no pc_update, no retire count.
REQ-028 The watchdog counter SHALL clear on every entry to FETCH or MEM and increment each cycle spent waiting in FETCH or MEM.
REQ-029 When the watchdog reaches 2^TIMEOUT_W-1 with no response that cycle, the next state SHALL be ERROR.
REQ-030 If a response arrives in the same cycle the watchdog saturates, the response SHALL win and the normal transition is taken.
REQ-031 HALT: halted=1 and all requests and strobes are 0; HALT is sticky until rst.
REQ-032 ERROR: halted=1 and bus_error=1; ERROR is sticky until rst.
REQ-033 ifu_rsp_valid outside FETCH and lsu_rsp_valid outside MEM SHALL be ignored.
REQ-034 All outputs SHALL be decoded from the current state (Moore), except inst_en and rd_write_en:
  - inst_en = FETCH & ifu_rsp_valid;
  - rd_write_en = WB & dec_rd_write.
REQ-035 Minimum latency per instruction SHALL be:
  - non-memory: 3 cycles (FETCH, DECODE, WB) with a same-cycle fetch response;
  - memory: 4 cycles (FETCH, DECODE, MEM, WB).

Reset
REQ-036 While rst=1 the FSM SHALL enter IDLE and clear the watchdog and inst_retired.
REQ-037 While rst=1 and on the first cycle after it, all outputs SHALL be 0.
REQ-038 rst asserted mid-access (FETCH/MEM) SHALL drop ifu_req/lsu_req on the following cycle; the outstanding response is discarded.

Verification
REQ-039 Reset release, ifu_rsp_valid tied 1, decode all 0 except dec_rd_write=1:
  - IDLE, then FETCH/DECODE/WB repeats;
  - rd_write_en and pc_update pulse every 3rd cycle;
  - inst_retired=10 after 30 cycles.
REQ-040 Load with lsu_rsp_valid delayed 5 cycles:
  - lsu_req=1 with lsu_we=0 for 6 cycles;
  - then WB with rd_write_en=1, inst_retired +1.
REQ-041 Store (dec_mem_write=1, dec_rd_write=0):
  - lsu_we=1 during MEM;
  - rd_write_en=0 in WB; pc_update=1.
REQ-042 dec_ebreak=1 in DECODE -> halted=1 next cycle and stays 1 for 100 cycles; inst_retired unchanged; rst restores IDLE.
REQ-043 TIMEOUT_W=4, ifu_rsp_valid held 0:
  - bus_error=halted=1 after 15 waiting cycles;
  - response on cycle 15 instead -> DECODE, no error.
REQ-044 rst pulsed during MEM wait -> lsu_req=0 next cycle, state IDLE; a late lsu_rsp_valid causes no WB.

Source files
------------

// File: rtl/core_seq.sv
// core_seq: multi-cycle control sequencer for a simple in-order core.
//
// Each instruction is walked through FETCH -> DECODE -> (MEM) -> WB. A watchdog
// counts the cycles spent waiting on the instruction or data bus. If it expires,
// the core parks in ERROR. An ebreak parks the core in HALT. Both parked states
// hold until rst.
//
// Parameters
//   TIMEOUT_W      width of the bus-response watchdog counter
//   XLEN           width of the retired-instruction counter
//
// Ports
//   clk            core clock; every state change happens on its rising edge
//   rst            synchronous, active-high reset
//   ifu_req        fetch request, held high while in FETCH
//   ifu_rsp_valid  fetch data valid (ignored outside FETCH)
//   inst_en        instruction-register load enable (FETCH & ifu_rsp_valid)
//   dec_mem_read   decoded load
//   dec_mem_write  decoded store
//   dec_rd_write   decoded destination-register write
//   dec_ebreak     decoded ebreak
//   lsu_req        data request, held high while in MEM
//   lsu_we         data request is a write (meaningful only with lsu_req)
//   lsu_rsp_valid  data response/ack (ignored outside MEM)
//   rd_write_en    register-file write strobe (WB & dec_rd_write)
//   pc_update      PC load strobe, one cycle per retired instruction
//   halted         core stopped by ebreak or bus error
//   bus_error      watchdog expired on a fetch or data access
//   inst_retired   retired-instruction count, wraps to zero

module core_seq #(
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned XLEN      = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_req,
  input  logic            ifu_rsp_valid,
  output logic            inst_en,
  input  logic            dec_mem_read,
  input  logic            dec_mem_write,
  input  logic            dec_rd_write,
  input  logic            dec_ebreak,
  output logic            lsu_req,
  output logic            lsu_we,
  input  logic            lsu_rsp_valid,
  output logic            rd_write_en,
  output logic            pc_update,
  output logic            halted,
  output logic            bus_error,
  output logic [XLEN-1:0] inst_retired
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5,
    StError  = 3'd6
  } state_e;

  localparam logic [TIMEOUT_W-1:0] WdogLast = {TIMEOUT_W{1'b1}};

  state_e                 state_q, state_d;
  logic [TIMEOUT_W-1:0]   wdog_q, wdog_d;
  logic [XLEN-1:0]        retired_q, retired_d;

  logic [TIMEOUT_W-1:0]   wdog_inc;
  logic                   waiting;
  logic                   wdog_expire;

  // ---------------------------------------------------------------------------
  // State register (plus the watchdog and retire counter that follow it)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      wdog_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      retired_q <= retired_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  // wdog_q counts the cycles already spent waiting. This cycle is the one that
  // brings the count to all-ones. If no response arrives in it, the access has
  // timed out. A response in the same cycle takes priority over the timeout.
  always_comb begin
    wdog_inc    = wdog_q + TIMEOUT_W'(1);
    waiting     = ((state_q == StFetch) && !ifu_rsp_valid) ||
                  ((state_q == StMem)   && !lsu_rsp_valid);
    wdog_expire = waiting && (wdog_inc == WdogLast);
  end

  // Counting only while the state repeats means every fresh entry into FETCH
  // or MEM starts from zero.
  always_comb begin
    wdog_d = '0;
    if (waiting && (state_d == state_q)) begin
      wdog_d = wdog_inc;
    end
  end

  always_comb begin
    retired_d = retired_q;
    if (state_q == StWb) begin
      retired_d = retired_q + XLEN'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (ifu_rsp_valid) begin
          state_d = StDecode;
        end else if (wdog_expire) begin
          state_d = StError;
        end
      end
      StDecode: begin
        if (dec_ebreak) begin
          state_d = StHalt;
        end else if (dec_mem_read || dec_mem_write) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (lsu_rsp_valid) begin
          state_d = StWb;
        end else if (wdog_expire) begin
          state_d = StError;
        end
      end
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      StError: state_d = StError;
      // An unused encoding can only come from corruption; park the core.
      default: state_d = StError;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  // Outputs are masked while rst is high. This drops outstanding requests in
  // the reset cycle itself, and it also covers the undefined state before the
  // first clock edge.
  always_comb begin
    ifu_req      = 1'b0;
    inst_en      = 1'b0;
    lsu_req      = 1'b0;
    lsu_we       = 1'b0;
    rd_write_en  = 1'b0;
    pc_update    = 1'b0;
    halted       = 1'b0;
    bus_error    = 1'b0;
    inst_retired = '0;
    if (!rst) begin
      inst_retired = retired_q;
      unique case (state_q)
        StFetch: begin
          ifu_req = 1'b1;
          inst_en = ifu_rsp_valid;
        end
        StMem: begin
          lsu_req = 1'b1;
          lsu_we  = dec_mem_write;
        end
        StWb: begin
          pc_update   = 1'b1;
          rd_write_en = dec_rd_write;
        end
        StHalt: halted = 1'b1;
        StError: begin
          halted    = 1'b1;
          bus_error = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
